// File: rtl/mem_fifo_stage_if.sv
// Request stream between a producer and a memory port: valid/ready handshake
// carrying a read/write request with address, write data and transaction id.
interface mem_intf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              valid;
    logic              ready;
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;

    // Consumer-side view: receives requests, drives ready.
    modport in (
        input  valid, read_enable, write_enable, addr, data, id,
        output ready
    );

    // Producer-side view: drives requests, receives ready.
    modport out (
        output valid, read_enable, write_enable, addr, data, id,
        input  ready
    );

    modport slave (
        input  valid, read_enable, write_enable, addr, data, id,
        output ready
    );

    modport master (
        output valid, read_enable, write_enable, addr, data, id,
        input  ready
    );
endinterface

// File: rtl/mem_fifo_stage.sv
// Elastic DEPTH-entry buffer for mem_intf request streams. Entries are kept
// unmodified in strict FIFO order, with optional same-cycle fall-through when
// empty, occupancy / almost-full reporting and a synchronous flush.
module mem_fifo_stage #(
    parameter              CLOCK_INFO   = 1'b0,
    parameter int          DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int          ALMOST_FULL  = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_intf.in                        mem_in,
    mem_intf.out                       mem_out,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    localparam int ADDR_W  = $bits(mem_in.addr);
    localparam int DATA_W  = $bits(mem_in.data);
    localparam int ID_W    = $bits(mem_in.id);
    localparam int ENTRY_W = 2 + ADDR_W + DATA_W + ID_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_fifo_stage: DEPTH must be a power of two >= 2");
    end
    if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
        $error("mem_fifo_stage: ALMOST_FULL must lie in 1..DEPTH");
    end
    if ($bits(mem_out.addr) != ADDR_W || $bits(mem_out.data) != DATA_W ||
        $bits(mem_out.id) != ID_W) begin : g_bad_widths
        $error("mem_fifo_stage: mem_in and mem_out field widths differ");
    end
    if ($bits(CLOCK_INFO) < 1) begin : g_bad_clock_info
        $error("mem_fifo_stage: CLOCK_INFO must be non-empty");
    end

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count_q;

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] out_entry;
    logic               is_empty;
    logic               is_full;
    logic               bypass;
    logic               in_ready;
    logic               out_valid;
    logic               push;
    logic               pop;
    logic               wr_en;
    logic               rd_en;

    assign in_entry = {mem_in.read_enable, mem_in.write_enable,
                       mem_in.addr, mem_in.data, mem_in.id};

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // Fall-through only applies while nothing is buffered, so order is kept.
    assign bypass    = FALL_THROUGH && is_empty && !flush;

    // Ready looks only at registered occupancy: a full buffer refuses a push
    // even when a pop happens in the same cycle.
    assign in_ready  = !rst && !flush && !is_full;
    assign out_valid = !rst && !flush && (!is_empty || (bypass && mem_in.valid));

    assign push  = mem_in.valid && in_ready;
    assign pop   = out_valid && mem_out.ready;

    // A fall-through beat taken downstream in the same cycle is never stored.
    assign wr_en = push && !(bypass && mem_out.ready);
    assign rd_en = pop && !is_empty;

    // Select the head entry (or the fall-through beat) and blank idle payload.
    always_comb begin
        out_entry = '0;
        if (out_valid) begin
            out_entry = is_empty ? in_entry : storage[rd_ptr];
        end
    end

    assign mem_in.ready  = in_ready;
    assign mem_out.valid = out_valid;
    assign {mem_out.read_enable, mem_out.write_enable,
            mem_out.addr, mem_out.data, mem_out.id} = out_entry;

    assign count       = count_q;
    assign almost_full = (count_q >= CNT_W'(ALMOST_FULL));

    // Pointer and occupancy bookkeeping; flush empties the buffer at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage holds data only and is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_ptr] <= in_entry;
        end
    end
endmodule

// File: tb/tb_mem_fifo_stage.sv
// Bench for mem_fifo_stage: one registered (FALL_THROUGH=0) and one
// fall-through (FALL_THROUGH=1) instance, DEPTH=4, ALMOST_FULL=3.
module tb_mem_fifo_stage;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int EW = 2 + AW + DW + IW;

    localparam logic [2:0] K_COUNT = 3'd0;
    localparam logic [2:0] K_AF    = 3'd1;
    localparam logic [2:0] K_IRDY  = 3'd2;
    localparam logic [2:0] K_OVLD  = 3'd3;
    localparam logic [2:0] K_OADDR = 3'd4;
    localparam logic [2:0] K_TMO   = 3'd5;

    typedef struct packed {
        logic          k;
        logic [2:0]    kind;
        logic [EW-1:0] val;
    } dexp_t;

    logic clk;
    logic rst;
    logic flush;

    logic          in_v    [2];
    logic [EW-1:0] in_pay  [2];
    logic          o_rdy   [2];
    logic          in_rdy  [2];
    logic          out_v   [2];
    logic [EW-1:0] out_pay [2];
    logic [2:0]    cnt     [2];
    logic          af      [2];

    int checks;
    int errors;

    logic [EW-1:0] q [2][$];
    dexp_t         dq[$];
    logic          rand_done;

    mem_intf #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) in0  ();
    mem_intf #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) out0 ();
    mem_intf #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) in1  ();
    mem_intf #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) out1 ();

    assign in0.valid = in_v[0];
    assign {in0.read_enable, in0.write_enable, in0.addr, in0.data, in0.id} = in_pay[0];
    assign in_rdy[0] = in0.ready;
    assign out0.ready = o_rdy[0];
    assign out_v[0] = out0.valid;
    assign out_pay[0] = {out0.read_enable, out0.write_enable, out0.addr, out0.data, out0.id};

    assign in1.valid = in_v[1];
    assign {in1.read_enable, in1.write_enable, in1.addr, in1.data, in1.id} = in_pay[1];
    assign in_rdy[1] = in1.ready;
    assign out1.ready = o_rdy[1];
    assign out_v[1] = out1.valid;
    assign out_pay[1] = {out1.read_enable, out1.write_enable, out1.addr, out1.data, out1.id};

    mem_fifo_stage #(.DEPTH(4), .FALL_THROUGH(1'b0), .ALMOST_FULL(3)) dut0 (
        .clk(clk), .rst(rst), .mem_in(in0), .mem_out(out0),
        .flush(flush), .count(cnt[0]), .almost_full(af[0])
    );

    mem_fifo_stage #(.DEPTH(4), .FALL_THROUGH(1'b1), .ALMOST_FULL(3)) dut1 (
        .clk(clk), .rst(rst), .mem_in(in1), .mem_out(out1),
        .flush(flush), .count(cnt[1]), .almost_full(af[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int k, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic re, input logic we,
                                         input logic [AW-1:0] a, input logic [IW-1:0] id);
        logic [DW-1:0] d;
        d = $urandom;
        return {re, we, a, d, id};
    endfunction

    function automatic logic [EW-1:0] rnd_entry();
        return {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom), DW'($urandom), IW'($urandom)};
    endfunction

    task automatic expect_at_next(input int k, input logic [2:0] kind, input logic [EW-1:0] v);
        dexp_t d;
        d.k = k[0];
        d.kind = kind;
        d.val = v;
        dq.push_back(d);
    endtask

    // Present one beat and hold it until the instance accepts it.
    task automatic send(input int k, input logic [EW-1:0] e);
        int t;
        t = 0;
        in_v[k] = 1'b1;
        in_pay[k] = e;
        @(negedge clk);
        while (!in_rdy[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) expect_at_next(k, K_TMO, '0);
        @(posedge clk);
        #1;
        in_v[k] = 1'b0;
        in_pay[k] = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: directed expectations first, then the reference model per instance.
    always @(negedge clk) begin
        while (dq.size() > 0) begin
            dexp_t d;
            int kk;
            d = dq.pop_front();
            kk = int'(d.k);
            case (d.kind)
                K_COUNT: chk("dir_count", kk, EW'(cnt[kk]), d.val);
                K_AF:    chk("dir_almost_full", kk, EW'(af[kk]), d.val);
                K_IRDY:  chk("dir_in_ready", kk, EW'(in_rdy[kk]), d.val);
                K_OVLD:  chk("dir_out_valid", kk, EW'(out_v[kk]), d.val);
                K_OADDR: chk("dir_out_addr", kk, EW'(out_pay[kk][IW+DW +: AW]), d.val);
                default: chk("send_timeout", kk, EW'(1), EW'(0));
            endcase
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                chk("rst_in_ready", k, EW'(in_rdy[k]), '0);
                chk("rst_out_valid", k, EW'(out_v[k]), '0);
                chk("rst_count", k, EW'(cnt[k]), '0);
                q[k].delete();
            end else begin
                int n;
                logic exp_rdy, exp_v;
                logic [EW-1:0] exp_pay;
                n = q[k].size();
                exp_rdy = !flush && (n != 4);
                exp_v = !flush && ((n != 0) || (k == 1 && in_v[k]));
                chk("count", k, EW'(cnt[k]), EW'(n));
                chk("almost_full", k, EW'(af[k]), EW'(n >= 3));
                chk("in_ready", k, EW'(in_rdy[k]), EW'(exp_rdy));
                if (in_v[k] && exp_rdy) q[k].push_back(in_pay[k]);
                exp_pay = exp_v ? q[k][0] : '0;
                chk("out_valid", k, EW'(out_v[k]), EW'(exp_v));
                chk("out_payload", k, out_pay[k], exp_pay);
                if (exp_v && o_rdy[k]) void'(q[k].pop_front());
                if (flush) q[k].delete();
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rand_done = 1'b0;
        rst = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_v[k] = 1'b1;
            in_pay[k] = mk(1'b1, 1'b0, 16'h00AA, 4'h1);
            o_rdy[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_v[0] = 1'b0;
        in_v[1] = 1'b0;
        in_pay[0] = '0;
        in_pay[1] = '0;
        expect_at_next(0, K_IRDY, EW'(1));
        expect_at_next(1, K_IRDY, EW'(1));
        cycle();

        // Fill the registered instance while downstream stalls.
        o_rdy[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(0, mk(1'b0, 1'b1, AW'(16'h10 + i), IW'(i)));
            expect_at_next(0, K_COUNT, EW'(i + 1));
            expect_at_next(0, K_AF, EW'(i >= 2));
            expect_at_next(0, K_IRDY, EW'(i < 3));
        end
        cycle();
        expect_at_next(0, K_COUNT, EW'(4));

        // Drain in order; the held fifth beat enters once space opens.
        fork
            send(0, mk(1'b1, 1'b0, 16'h0014, 4'h4));
        join_none
        o_rdy[0] = 1'b1;
        wait fork;
        repeat (6) cycle();
        expect_at_next(0, K_COUNT, EW'(0));
        cycle();

        // Fall-through instance: same-cycle forward, then storage when stalled.
        o_rdy[1] = 1'b1;
        in_v[1] = 1'b1;
        in_pay[1] = mk(1'b1, 1'b0, 16'h0040, 4'h5);
        expect_at_next(1, K_OVLD, EW'(1));
        expect_at_next(1, K_OADDR, EW'(16'h0040));
        expect_at_next(1, K_COUNT, EW'(0));
        cycle();
        in_v[1] = 1'b0;
        expect_at_next(1, K_COUNT, EW'(0));
        o_rdy[1] = 1'b0;
        send(1, mk(1'b0, 1'b1, 16'h0041, 4'h6));
        expect_at_next(1, K_COUNT, EW'(1));
        expect_at_next(1, K_OADDR, EW'(16'h0041));
        o_rdy[1] = 1'b1;
        cycle();
        expect_at_next(1, K_COUNT, EW'(0));
        cycle();

        // Flush with three entries buffered and a beat on the input.
        o_rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) send(0, mk(1'b0, 1'b1, AW'(16'h60 + i), IW'(i)));
        expect_at_next(0, K_COUNT, EW'(3));
        cycle();
        flush = 1'b1;
        in_v[0] = 1'b1;
        in_pay[0] = mk(1'b0, 1'b1, 16'h0063, 4'h3);
        expect_at_next(0, K_IRDY, EW'(0));
        expect_at_next(0, K_OVLD, EW'(0));
        cycle();
        flush = 1'b0;
        in_v[0] = 1'b0;
        expect_at_next(0, K_COUNT, EW'(0));
        expect_at_next(0, K_OVLD, EW'(0));
        send(0, mk(1'b1, 1'b0, 16'h0070, 4'h7));
        expect_at_next(0, K_OADDR, EW'(16'h0070));
        o_rdy[0] = 1'b1;
        repeat (2) cycle();

        // Back-to-back streaming on both instances.
        fork
            for (int i = 0; i < 100; i++) send(0, rnd_entry());
            for (int i = 0; i < 100; i++) send(1, rnd_entry());
        join
        repeat (3) cycle();

        // Random traffic, random backpressure and occasional flush.
        fork
            begin
                fork
                    for (int i = 0; i < 150; i++) begin
                        repeat ($urandom_range(0, 2)) cycle();
                        send(0, rnd_entry());
                    end
                    for (int i = 0; i < 150; i++) begin
                        repeat ($urandom_range(0, 2)) cycle();
                        send(1, rnd_entry());
                    end
                join
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                cycle();
                o_rdy[0] = 1'($urandom_range(0, 1));
                o_rdy[1] = 1'($urandom_range(0, 1));
                flush = ($urandom_range(0, 24) == 0);
            end
        join
        flush = 1'b0;
        o_rdy[0] = 1'b1;
        o_rdy[1] = 1'b1;
        repeat (8) cycle();
        expect_at_next(0, K_COUNT, EW'(0));
        expect_at_next(1, K_COUNT, EW'(0));
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
